// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: derives a half-rate pixel tick from CLK_IN, runs the h/v counters,
// drives a sequential framebuffer read address and registers syncs, blanking and RGB for the DAC.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned COLOR_W  = 8,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic                 CLK_IN,
  input  logic                 RESET,
  input  logic                 ENABLE,
  input  logic [3*COLOR_W-1:0] RGB_IN,
  output logic                 PIX_TICK,
  output logic [9:0]           PIX_X,
  output logic [9:0]           PIX_Y,
  output logic [ADDR_W-1:0]    FETCH_ADDR,
  output logic                 FETCH_EN,
  output logic                 HSYNC,
  output logic                 VSYNC,
  output logic                 VIDEO_ON,
  output logic [COLOR_W-1:0]   VGA_R,
  output logic [COLOR_W-1:0]   VGA_G,
  output logic [COLOR_W-1:0]   VGA_B,
  output logic                 FRAME_START
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  logic              toggle_q;
  logic              tick;
  logic [9:0]        hc_q, hc_d;
  logic [9:0]        vc_q, vc_d;
  logic              hc_wrap, vc_wrap;
  logic              active, active_d;
  logic              hs, vs;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              fetch_en_q;
  logic              video_on_q, hsync_q, vsync_q;
  logic [COLOR_W-1:0] r_q, g_q, b_q;

  // Freeze wins over a pending tick: gating with ENABLE suppresses it.
  assign tick    = ENABLE & toggle_q;
  assign hc_wrap = (hc_q == H_LAST);
  assign vc_wrap = (vc_q == V_LAST);

  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (tick) begin
      if (hc_wrap) begin
        hc_d = '0;
        vc_d = vc_wrap ? '0 : vc_q + 10'd1;
      end else begin
        hc_d = hc_q + 10'd1;
      end
    end
  end

  assign active   = (hc_q < H_ACT) && (vc_q < V_ACT);
  assign active_d = (hc_d < H_ACT) && (vc_d < V_ACT);
  assign hs       = (hc_q >= HS_FIRST) && (hc_q <= HS_LAST);
  assign vs       = (vc_q >= VS_FIRST) && (vc_q <= VS_LAST);

  // Address wraps after the last visible pixel so it never exceeds the framebuffer size.
  always_comb begin
    addr_d = addr_q;
    if (tick) begin
      if (hc_wrap && vc_wrap) begin
        addr_d = '0;
      end else if (active) begin
        addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      toggle_q   <= 1'b0;
      hc_q       <= '0;
      vc_q       <= '0;
      addr_q     <= '0;
      fetch_en_q <= 1'b0;
    end else begin
      if (ENABLE) begin
        toggle_q <= ~toggle_q;
      end
      hc_q       <= hc_d;
      vc_q       <= vc_d;
      addr_q     <= addr_d;
      fetch_en_q <= active_d;
    end
  end

  // RGB_IN already holds the data for the address presented since the previous tick.
  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      video_on_q <= 1'b0;
      hsync_q    <= ~SYNC_POL;
      vsync_q    <= ~SYNC_POL;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
    end else if (tick) begin
      video_on_q <= active;
      hsync_q    <= hs ? SYNC_POL : ~SYNC_POL;
      vsync_q    <= vs ? SYNC_POL : ~SYNC_POL;
      r_q        <= active ? RGB_IN[3*COLOR_W-1 -: COLOR_W] : '0;
      g_q        <= active ? RGB_IN[2*COLOR_W-1 -: COLOR_W] : '0;
      b_q        <= active ? RGB_IN[COLOR_W-1:0] : '0;
    end
  end

  assign PIX_TICK    = tick;
  assign PIX_X       = hc_q;
  assign PIX_Y       = vc_q;
  assign FETCH_ADDR  = addr_q;
  assign FETCH_EN    = fetch_en_q;
  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign VIDEO_ON    = video_on_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign FRAME_START = tick && (hc_q == '0) && (vc_q == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized scoreboard bench for vga_timing_gen on a shrunken raster; expectations come from
// tick-count arithmetic over the raster geometry, compared by a negedge monitor.
module tb_vga_timing_gen;

  localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VA = 6, VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FR = HT * VT;
  localparam int NPIX = HA * VA;

  typedef struct packed {
    logic        tick;
    logic        fs;
    logic        fen;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [18:0] addr;
  } cyc_t;

  typedef struct packed {
    logic        von;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
  } tick_t;

  logic        clk;
  logic        RESET, ENABLE;
  logic [23:0] ram_q;
  logic        PIX_TICK, FETCH_EN, HSYNC, VSYNC, VIDEO_ON, FRAME_START;
  logic [9:0]  PIX_X, PIX_Y;
  logic [18:0] FETCH_ADDR;
  logic [7:0]  VGA_R, VGA_G, VGA_B;

  int   total = 0;
  int   bad = 0;
  int   e;
  bit   fresh;
  bit   ram_mode;
  bit   mon_on;
  bit   pending;
  cyc_t  cyc_q[$];
  tick_t tick_q[$];
  cyc_t  mc;
  tick_t mt;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b0), .COLOR_W(8), .ADDR_W(19)
  ) dut (
    .CLK_IN(clk), .RESET(RESET), .ENABLE(ENABLE), .RGB_IN(ram_q),
    .PIX_TICK(PIX_TICK), .PIX_X(PIX_X), .PIX_Y(PIX_Y),
    .FETCH_ADDR(FETCH_ADDR), .FETCH_EN(FETCH_EN),
    .HSYNC(HSYNC), .VSYNC(VSYNC), .VIDEO_ON(VIDEO_ON),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .FRAME_START(FRAME_START)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int hc_of(input int n); return n % HT; endfunction
  function automatic int vc_of(input int n); return (n / HT) % VT; endfunction
  function automatic bit act(input int n); return hc_of(n) < HA && vc_of(n) < VA; endfunction
  function automatic bit in_hs(input int n);
    return hc_of(n) >= HA + HFP && hc_of(n) < HA + HFP + HS;
  endfunction
  function automatic bit in_vs(input int n);
    return vc_of(n) >= VA + VFP && vc_of(n) < VA + VFP + VS;
  endfunction
  // Visible pixels already passed in this frame, wrapping once the frame's pixels are used up.
  function automatic int faddr(input int n);
    int cnt;
    if (vc_of(n) < VA) cnt = vc_of(n) * HA + ((hc_of(n) < HA) ? hc_of(n) : HA);
    else cnt = NPIX;
    return cnt % NPIX;
  endfunction
  function automatic logic [23:0] ram_data(input int a, input bit m);
    return m ? 24'hFFFFFF : (24'(a) ^ 24'hA50000);
  endfunction

  // One-cycle synchronous framebuffer RAM.
  always @(posedge clk) ram_q <= ram_data(int'(FETCH_ADDR), ram_mode);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (RESET || !mon_on) begin
      pending = 1'b0;
    end else begin
      if (pending) begin
        if (tick_q.size() == 0) begin
          chk("unexpected_tick", 32'd1, 32'd0);
        end else begin
          mt = tick_q.pop_front();
          chk("video_on", VIDEO_ON, mt.von);
          chk("hsync", HSYNC, mt.hs);
          chk("vsync", VSYNC, mt.vs);
          chk("rgb", {VGA_R, VGA_G, VGA_B}, mt.rgb);
        end
      end
      if (cyc_q.size() == 0) begin
        chk("cycle_queue_empty", 32'd1, 32'd0);
      end else begin
        mc = cyc_q.pop_front();
        chk("pix_tick", PIX_TICK, mc.tick);
        chk("frame_start", FRAME_START, mc.fs);
        chk("fetch_en", FETCH_EN, mc.fen);
        chk("pix_x", PIX_X, mc.x);
        chk("pix_y", PIX_Y, mc.y);
        chk("fetch_addr", FETCH_ADDR, mc.addr);
      end
      pending = PIX_TICK;
    end
  end

  // Entered just after a posedge; drives ENABLE for the coming edge and predicts its effect.
  task automatic step(input bit en);
    int    done;
    int    p;
    cyc_t  c;
    tick_t t;
    ENABLE = en;
    done   = e / 2;
    c.tick = en && (e % 2 == 1);
    c.fs   = c.tick && (done % FR == 0);
    c.fen  = fresh ? 1'b0 : act(done);
    c.x    = 10'(hc_of(done));
    c.y    = 10'(vc_of(done));
    c.addr = 19'(faddr(done));
    cyc_q.push_back(c);
    @(posedge clk);
    if (en) begin
      if (e % 2 == 1) begin
        p     = e / 2;
        t.von = act(p);
        t.hs  = !in_hs(p);
        t.vs  = !in_vs(p);
        t.rgb = act(p) ? ram_data(faddr(p), ram_mode) : 24'h0;
        tick_q.push_back(t);
      end
      e++;
    end
    fresh = 1'b0;
    #1;
  endtask

  task automatic check_reset();
    chk("rst_pix_tick", PIX_TICK, 0);
    chk("rst_frame_start", FRAME_START, 0);
    chk("rst_pix_x", PIX_X, 0);
    chk("rst_pix_y", PIX_Y, 0);
    chk("rst_fetch_addr", FETCH_ADDR, 0);
    chk("rst_fetch_en", FETCH_EN, 0);
    chk("rst_video_on", VIDEO_ON, 0);
    chk("rst_hsync", HSYNC, 1);
    chk("rst_vsync", VSYNC, 1);
    chk("rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    RESET = 1'b0;
    e     = 0;
    fresh = 1'b1;
  endtask

  // Asserted between edges, so it lands mid-line.
  task automatic do_reset(input bit mode);
    #1;
    RESET  = 1'b1;
    ENABLE = 1'b0;
    tick_q.delete();
    cyc_q.delete();
    ram_mode = mode;
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    release_reset();
  endtask

  initial begin
    RESET    = 1'b1;
    ENABLE   = 1'b0;
    ram_mode = 1'b0;
    mon_on   = 1'b1;
    pending  = 1'b0;
    e        = 0;
    fresh    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    release_reset();

    repeat (1500) step($urandom_range(0, 4) != 0);

    // Long freeze while PIX_X sits at 10.
    for (int i = 0; i < 200 && !((e % 2 == 0) && (hc_of(e / 2) == 10)); i++) step(1'b1);
    repeat (100) step(1'b0);
    repeat (200) step(1'b1);

    do_reset(1'b1);
    repeat (1500) step($urandom_range(0, 3) != 0);

    do_reset(1'b0);
    repeat (1400) step(1'b1);

    repeat (4) step(1'b0);
    mon_on = 1'b0;
    chk("tick_queue_drained", tick_q.size(), 0);
    chk("cycle_queue_drained", cyc_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
